// File: rtl/ospi_flash_ctrl.sv
// ospi_flash_ctrl: burst command sequencer in front of an OSPI flash model.
// Accepts read / write / erase bursts (start address + beat count), drives
// chip select and one enable per beat, streams read data back, and holds
// chip select high for CS_HIGH cycles between bursts.
// Optional build macro OSPI_CTRL_VERIFY_EN: after a write burst the same
// addresses are re-read and compared against a shadow copy of the written
// bytes; any difference raises the sticky verify_err output.
module ospi_flash_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int CS_HIGH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_data,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              cmd_err,
    output logic              flash_cs,
    output logic              flash_we,
    output logic              flash_re,
    output logic              flash_ee,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [7:0]        flash_din,
    input  logic [7:0]        flash_dout
`ifdef OSPI_CTRL_VERIFY_EN
    ,
    output logic              verify_err
`endif
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [3:0] HOLD_INIT = 4'(CS_HIGH - 1);
`ifdef OSPI_CTRL_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_XFER   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ERR    = 3'd4,
        ST_VSETUP = 3'd5,
        ST_VXFER  = 3'd6
    } state_t;

    state_t              state_reg, state_next;
    logic [1:0]          op_reg, op_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic [3:0]          hold_reg, hold_next;
    logic                cmd_ready_reg, busy_reg, done_reg, cmd_err_reg;
    logic                cs_reg, re_reg, ee_reg, wr_en_reg, rd_valid_reg;
    logic                accept, beat;

    assign accept = cmd_valid && cmd_ready_reg;
    // A beat completes every XFER cycle, except writes wait for wr_valid.
    assign beat   = (state_reg == ST_XFER) && ((op_reg != OP_WRITE) || wr_valid);

`ifdef OSPI_CTRL_VERIFY_EN
    logic [ADDR_W-1:0] start_reg;
    logic [7:0]        len_reg;
    logic [7:0]        idx_reg;
    logic              vchk_reg;
    logic              verify_err_reg;
    logic [7:0]        shadow_mem [256];
    logic [7:0]        shadow_q_reg;
`endif

    // Next-state and datapath-next computation for the burst sequencer.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        addr_next  = addr_reg;
        cnt_next   = cnt_reg;
        hold_next  = hold_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    op_next    = cmd_op;
                    addr_next  = cmd_addr;
                    cnt_next   = cmd_len;
                    state_next = (cmd_op == OP_RSVD) ? ST_ERR : ST_SETUP;
                end
            end
            ST_SETUP: state_next = ST_XFER;
            ST_XFER: begin
                if (beat) begin
                    addr_next = addr_reg + 1'b1;
                    cnt_next  = cnt_reg - 8'd1;
                    if (cnt_reg == 8'd0) begin
                        hold_next  = HOLD_INIT;
                        state_next = (VERIFY_EN && op_reg == OP_WRITE) ? ST_VSETUP : ST_HOLD;
                    end
                end
            end
`ifdef OSPI_CTRL_VERIFY_EN
            ST_VSETUP: begin
                addr_next  = start_reg;
                cnt_next   = len_reg;
                state_next = ST_VXFER;
            end
            ST_VXFER: begin
                addr_next = addr_reg + 1'b1;
                cnt_next  = cnt_reg - 8'd1;
                if (cnt_reg == 8'd0) begin
                    hold_next  = HOLD_INIT;
                    state_next = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                if (hold_reg == 4'd0) state_next = ST_IDLE;
                else                  hold_next  = hold_reg - 4'd1;
            end
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus all flash/host outputs registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_READ;
            addr_reg      <= '0;
            cnt_reg       <= '0;
            hold_reg      <= '0;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cmd_err_reg   <= 1'b0;
            cs_reg        <= 1'b1;
            re_reg        <= 1'b0;
            ee_reg        <= 1'b0;
            wr_en_reg     <= 1'b0;
            rd_valid_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            addr_reg      <= addr_next;
            cnt_reg       <= cnt_next;
            hold_reg      <= hold_next;
            cmd_ready_reg <= (state_next == ST_IDLE);
            busy_reg      <= (state_next != ST_IDLE);
            done_reg      <= (state_next == ST_ERR) ||
                             ((state_next == ST_HOLD) && (hold_next == 4'd0));
            cmd_err_reg   <= (state_next == ST_ERR);
            cs_reg        <= !((state_next == ST_SETUP) || (state_next == ST_XFER) ||
                               (state_next == ST_VSETUP) || (state_next == ST_VXFER));
            re_reg        <= ((state_next == ST_XFER) && (op_next == OP_READ)) ||
                             (state_next == ST_VXFER);
            ee_reg        <= (state_next == ST_XFER) && (op_next == OP_ERASE);
            wr_en_reg     <= (state_next == ST_XFER) && (op_next == OP_WRITE);
            rd_valid_reg  <= beat && (op_reg == OP_READ);
        end
    end

`ifdef OSPI_CTRL_VERIFY_EN
    // Burst bookkeeping for verify: start/len copy, beat index, compare strobe and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_reg      <= '0;
            len_reg        <= '0;
            idx_reg        <= '0;
            vchk_reg       <= 1'b0;
            verify_err_reg <= 1'b0;
        end else begin
            vchk_reg <= (state_reg == ST_VXFER);
            if (accept) begin
                start_reg      <= cmd_addr;
                len_reg        <= cmd_len;
                idx_reg        <= '0;
                verify_err_reg <= 1'b0;
            end else begin
                if (state_reg == ST_VSETUP)
                    idx_reg <= '0;
                else if ((beat && op_reg == OP_WRITE) || state_reg == ST_VXFER)
                    idx_reg <= idx_reg + 8'd1;
                if (vchk_reg && (flash_dout != shadow_q_reg))
                    verify_err_reg <= 1'b1;
            end
        end
    end

    // Shadow buffer of written bytes, indexed by beat number, with registered read.
    always_ff @(posedge clk) begin
        if (beat && op_reg == OP_WRITE)
            shadow_mem[idx_reg] <= wr_data;
        shadow_q_reg <= shadow_mem[idx_reg];
    end

    assign verify_err = verify_err_reg;
`endif

    assign cmd_ready  = cmd_ready_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign cmd_err    = cmd_err_reg;
    assign flash_cs   = cs_reg;
    assign flash_re   = re_reg;
    assign flash_ee   = ee_reg;
    assign flash_addr = addr_reg;
    assign wr_ready   = wr_en_reg;
    assign flash_we   = wr_en_reg & wr_valid;
    assign flash_din  = wr_en_reg ? wr_data : 8'h00;
    assign rd_valid   = rd_valid_reg;
    assign rd_data    = rd_valid_reg ? flash_dout : 8'h00;

endmodule

// File: tb/tb_ospi_flash_ctrl.sv
// Self-checking bench for ospi_flash_ctrl: directed and random bursts against
// a flash memory model, checked with a reference memory image and cycle-count
// expectations derived from the burst timing rules.
module tb_ospi_flash_ctrl;
    localparam int ADDR_W  = 8;
    localparam int CS_HIGH = 2;

    logic              clk;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [7:0]        wr_data;
    logic              rd_valid;
    logic [7:0]        rd_data;
    logic              busy;
    logic              done;
    logic              cmd_err;
    logic              flash_cs;
    logic              flash_we;
    logic              flash_re;
    logic              flash_ee;
    logic [ADDR_W-1:0] flash_addr;
    logic [7:0]        flash_din;
    logic [7:0]        flash_dout;
`ifdef OSPI_CTRL_VERIFY_EN
    logic              verify_err;
    bit                exp_verr;
`endif

    ospi_flash_ctrl #(.ADDR_W(ADDR_W), .CS_HIGH(CS_HIGH)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .cmd_err(cmd_err),
        .flash_cs(flash_cs), .flash_we(flash_we), .flash_re(flash_re), .flash_ee(flash_ee),
        .flash_addr(flash_addr), .flash_din(flash_din), .flash_dout(flash_dout)
`ifdef OSPI_CTRL_VERIFY_EN
        , .verify_err(verify_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash memory model: write/erase/read on the rising edge while selected.
    logic [7:0] fmem [256];
    logic [7:0] init_img [256];
    logic [7:0] dout_q;
    logic [7:0] corrupt_mask;
    logic       init_req;
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 256; i++) fmem[i] <= init_img[i];
            dout_q <= 8'h00;
        end else if (!flash_cs) begin
            if (flash_we) fmem[flash_addr] <= flash_din;
            if (flash_ee) fmem[flash_addr] <= 8'hFF;
            if (flash_re) dout_q <= fmem[flash_addr];
        end
    end
    assign flash_dout = dout_q ^ corrupt_mask;

    // Reference model state and stimulus tables.
    logic [7:0] ref_mem [256];
    logic [7:0] wdata [256];
    int         gaps [257];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input string name, input int op, input int addr, input int len,
                           input int abort_c);
        int n, s_tot, vx, wbeat, gap_left, ready_c;
        int cs_low, cs_first, cs_last, done_n, done_c, err_n, mutex_bad, rd_first, rd_last;
        int hold_start, exp_ready, exp_done, exp_cs, exp_we_n, exp_re_n, exp_ee_n, exp_rd_n;
        int nen;
        bit aborted;
        int we_a[$], we_d[$], re_a[$], ee_a[$], rd_d[$];
        int exp_rd[$];
        n = len + 1; s_tot = 0; vx = 0; wbeat = 0; ready_c = -1; aborted = 0;
        cs_low = 0; cs_first = -1; cs_last = -1; done_n = 0; done_c = -1; err_n = 0;
        mutex_bad = 0; rd_first = -1; rd_last = -1;
        gap_left = gaps[0];
        for (int i = 0; i < n; i++) exp_rd.push_back(int'(ref_mem[(addr + i) % 256]));

        for (int w = 0; w < 64; w++) begin
            @(negedge clk); #1;
            if (cmd_ready) break;
        end
        check({name, " ready_before"}, cmd_ready, 1);

        for (int c = 0; c < 700; c++) begin
            if (c > 0) @(negedge clk);
            // Inputs: command on cycle 0, an ignored reserved command on cycle 1.
            cmd_valid = (c <= 1);
            cmd_op    = (c == 0) ? 2'(op) : 2'b11;
            cmd_addr  = (c == 0) ? ADDR_W'(addr) : ADDR_W'($urandom);
            cmd_len   = (c == 0) ? 8'(len) : 8'($urandom);
            if (wr_ready && wbeat < n) begin
                if (gap_left > 0) begin
                    wr_valid = 1'b0;
                    wr_data  = 8'($urandom);
                    gap_left--;
                end else begin
                    wr_valid = 1'b1;
                    wr_data  = wdata[wbeat];
                    wbeat++;
                    gap_left = gaps[wbeat];
                end
            end else begin
                wr_valid = 1'($urandom);
                wr_data  = 8'($urandom);
            end
            #1;
            if (!flash_cs) begin
                cs_low++;
                if (cs_first < 0) cs_first = c;
                cs_last = c;
            end
            nen = int'(flash_we) + int'(flash_re) + int'(flash_ee);
            if (nen > 1 || (flash_cs && nen > 0)) mutex_bad++;
            if (flash_we) begin we_a.push_back(int'(flash_addr)); we_d.push_back(int'(flash_din)); end
            if (flash_re) re_a.push_back(int'(flash_addr));
            if (flash_ee) ee_a.push_back(int'(flash_addr));
            if (rd_valid) begin
                rd_d.push_back(int'(rd_data));
                if (rd_first < 0) rd_first = c;
                rd_last = c;
            end
            if (done) begin done_n++; done_c = c; end
            if (cmd_err) err_n++;
            if (c == abort_c) begin
                reset_n = 1'b0;
                #1;
                check({name, " abort cs"}, flash_cs, 1);
                check({name, " abort re"}, flash_re, 0);
                check({name, " abort we"}, flash_we, 0);
                check({name, " abort ee"}, flash_ee, 0);
                check({name, " abort done"}, done, 0);
                check({name, " abort busy"}, busy, 0);
                check({name, " abort cmd_ready"}, cmd_ready, 0);
                check({name, " abort rd_valid"}, rd_valid, 0);
                aborted = 1;
                break;
            end
            if (c > 0 && cmd_ready) begin
                ready_c = c;
                break;
            end
        end
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        if (aborted) begin
            $display("TXN %s op=%0d addr=%02h len=%0d aborted by reset", name, op, addr, len);
            return;
        end

        if (op == 1) for (int i = 0; i < n; i++) s_tot += gaps[i];
`ifdef OSPI_CTRL_VERIFY_EN
        if (op == 1) vx = 1 + n;
`endif
        if (op == 3) begin
            exp_done = 1; exp_ready = 2; exp_cs = 0;
        end else begin
            hold_start = 2 + n + s_tot + vx;
            exp_done   = hold_start + CS_HIGH - 1;
            exp_ready  = hold_start + CS_HIGH;
            exp_cs     = 1 + n + s_tot + vx;
        end
        exp_we_n = (op == 1) ? n : 0;
        exp_re_n = (op == 0 || (op == 1 && vx > 0)) ? n : 0;
        exp_ee_n = (op == 2) ? n : 0;
        exp_rd_n = (op == 0) ? n : 0;

        check({name, " ready_cycle"}, ready_c, exp_ready);
        check({name, " done_count"}, done_n, 1);
        check({name, " done_cycle"}, done_c, exp_done);
        check({name, " cmd_err_count"}, err_n, (op == 3) ? 1 : 0);
        check({name, " cs_low_cycles"}, cs_low, exp_cs);
        if (op != 3) begin
            check({name, " cs_first"}, cs_first, 1);
            check({name, " cs_contiguous"}, cs_last - cs_first + 1, cs_low);
        end
        check({name, " enable_exclusion"}, mutex_bad, 0);
        check({name, " we_count"}, we_a.size(), exp_we_n);
        for (int i = 0; i < we_a.size() && i < exp_we_n; i++) begin
            check({name, " we_addr"}, we_a[i], (addr + i) % 256);
            check({name, " we_data"}, we_d[i], int'(wdata[i]));
        end
        check({name, " re_count"}, re_a.size(), exp_re_n);
        for (int i = 0; i < re_a.size() && i < exp_re_n; i++)
            check({name, " re_addr"}, re_a[i], (addr + i) % 256);
        check({name, " ee_count"}, ee_a.size(), exp_ee_n);
        for (int i = 0; i < ee_a.size() && i < exp_ee_n; i++)
            check({name, " ee_addr"}, ee_a[i], (addr + i) % 256);
        check({name, " rd_count"}, rd_d.size(), exp_rd_n);
        for (int i = 0; i < rd_d.size() && i < exp_rd_n; i++)
            check({name, " rd_data"}, rd_d[i], exp_rd[i]);
        if (op == 0) begin
            check({name, " rd_first_cycle"}, rd_first, 3);
            check({name, " rd_last_cycle"}, rd_last, n + 2);
        end
`ifdef OSPI_CTRL_VERIFY_EN
        check({name, " verify_err"}, verify_err, exp_verr);
`endif
        if (op == 1) for (int i = 0; i < n; i++) ref_mem[(addr + i) % 256] = wdata[i];
        if (op == 2) for (int i = 0; i < n; i++) ref_mem[(addr + i) % 256] = 8'hFF;
        $display("TXN %s op=%0d addr=%02h len=%0d stalls=%0d done@%0d ready@%0d rd=%0d",
                 name, op, addr, len, s_tot, done_c, ready_c, rd_d.size());
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 257; i++) gaps[i] = 0;
        for (int i = 0; i < 256; i++) wdata[i] = 8'($urandom);
    endtask

    initial begin
        int r, op, addr, len;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = 8'h00; corrupt_mask = 8'h00; init_req = 1'b1;
`ifdef OSPI_CTRL_VERIFY_EN
        exp_verr = 1'b0;
`endif
        for (int i = 0; i < 256; i++) begin
            init_img[i] = 8'($urandom);
            ref_mem[i]  = init_img[i];
        end
        repeat (2) @(posedge clk);
        #1 init_req = 1'b0;

        // Reset state.
        @(negedge clk); #1;
        check("reset flash_cs", flash_cs, 1);
        check("reset cmd_ready", cmd_ready, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset cmd_err", cmd_err, 0);
        check("reset enables", {flash_we, flash_re, flash_ee}, 0);
        check("reset rd_valid", rd_valid, 0);
        check("reset flash_addr", flash_addr, 0);
`ifdef OSPI_CTRL_VERIFY_EN
        check("reset verify_err", verify_err, 0);
`endif
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("post_reset cmd_ready", cmd_ready, 1);

        // Directed bursts.
        clear_tables();
        wdata[0] = 8'hA1; wdata[1] = 8'hA2; wdata[2] = 8'hA3; wdata[3] = 8'hA4;
        run_cmd("wr_10", 1, 'h10, 3, -1);
        run_cmd("rd_10", 0, 'h10, 3, -1);
        run_cmd("er_fe", 2, 'hFE, 2, -1);
        run_cmd("rd_fe", 0, 'hFE, 2, -1);
        clear_tables();
        wdata[0] = 8'h5A; wdata[1] = 8'hC3; gaps[1] = 3;
        run_cmd("wr_stall", 1, 'h80, 1, -1);
        clear_tables();
        run_cmd("rd_stall", 0, 'h80, 1, -1);
        run_cmd("rsvd_op", 3, 'h33, 5, -1);
        run_cmd("rd_len0", 0, 'hFF, 0, -1);

        // Random bursts.
        for (int k = 0; k < 12; k++) begin
            clear_tables();
            r    = $urandom_range(0, 7);
            op   = (r < 3) ? 0 : (r < 6) ? 1 : (r < 7) ? 2 : 3;
            addr = $urandom_range(0, 255);
            len  = $urandom_range(0, 11);
            if (op == 1) for (int i = 0; i <= len; i++) gaps[i] = $urandom_range(0, 2);
            run_cmd($sformatf("rand%0d", k), op, addr, len, -1);
        end

        // Reset in the middle of a read burst, then recover.
        clear_tables();
        run_cmd("rd_abort", 0, 'h40, 7, 4);
        repeat (2) begin
            @(negedge clk); #1;
            check("in_reset done", done, 0);
            check("in_reset flash_cs", flash_cs, 1);
        end
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("after_abort cmd_ready", cmd_ready, 1);
        run_cmd("rd_recover", 0, 'h40, 7, -1);

`ifdef OSPI_CTRL_VERIFY_EN
        // Corrupt read-back during the verify pass, then a clean burst clears the flag.
        clear_tables();
        corrupt_mask = 8'h01;
        exp_verr = 1'b1;
        run_cmd("wr_verify_bad", 1, 'h20, 3, -1);
        corrupt_mask = 8'h00;
        exp_verr = 1'b0;
        clear_tables();
        run_cmd("wr_verify_ok", 1, 'h20, 3, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
